// File: rtl/la_pkg.sv
// Shared types and constants for the logic-analyzer capture engine.
package la_pkg;

    localparam int PROBE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/la_sample_ram.sv
// DEPTH x PROBE_W sample buffer: one write port, one registered read port.
module la_sample_ram
    import la_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [PROBE_W-1:0] wr_data,
    input  logic               rd_en,
    input  logic [AW-1:0]      rd_addr,
    output logic [PROBE_W-1:0] rd_data
);

    logic [PROBE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Only the read register is reset so readout starts from a known zero.
    always_ff @(posedge clk) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/la_capture_engine.sv
// Pre/post-trigger capture of 8 probe channels into a circular buffer with readout.
// Optional macro LA_EDGE_TRIG_EN: trigger also needs a masked-channel transition.
//
// state | meaning
// IDLE  | no capture, waiting for arm
// PRE   | filling PRETRIG pre-trigger samples, trigger ignored
// WAIT  | circular overwrite until trigger match
// POST  | filling remaining post-trigger samples
// DONE  | record frozen, readout allowed
module la_capture_engine
    import la_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int PRETRIG = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PROBE_W-1:0] probe_in,
    input  logic               arm,
    input  logic               abort,
    input  logic [PROBE_W-1:0] trig_mask,
    input  logic [PROBE_W-1:0] trig_value,
    input  logic               rd_en,
    output logic [PROBE_W-1:0] rd_data,
    output logic               rd_valid,
    output logic               rd_last,
    output logic [2:0]         state,
    output logic               triggered,
    output logic               done
);

    localparam int AW     = $clog2(DEPTH);
    localparam int POST_N = DEPTH - PRETRIG;
    localparam logic [AW-1:0] PRE_LOAD  = AW'((PRETRIG > 0) ? PRETRIG - 1 : 0);
    localparam logic [AW-1:0] POST_LOAD = AW'((POST_N > 1) ? POST_N - 2 : 0);
    localparam logic [AW-1:0] PRE_OFS   = AW'(PRETRIG);
    localparam logic [AW-1:0] ONE       = AW'(1);
    localparam logic [AW:0]   RD_LOAD   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   RD_ONE    = (AW+1)'(1);

    state_e        cur_state;
    logic [AW-1:0] wptr, tptr, rptr, cnt;
    logic [AW:0]   rd_left;
    logic          capturing, level_hit, hit, rd_fire;

    assign capturing = (cur_state == ST_PRE) || (cur_state == ST_WAIT) || (cur_state == ST_POST);
    assign level_hit = ((probe_in ^ trig_value) & trig_mask) == '0;

`ifdef LA_EDGE_TRIG_EN
    logic [PROBE_W-1:0] prev_probe;

    always_ff @(posedge clk) begin
        if (rst) prev_probe <= '0;
        else     prev_probe <= probe_in;
    end

    assign hit = level_hit && (((probe_in ^ prev_probe) & trig_mask) != '0);
`else
    assign hit = level_hit;
`endif

    // arm/abort pre-empt a pop issued in the same cycle.
    assign rd_fire = (cur_state == ST_DONE) && rd_en && (rd_left != '0) && !arm && !abort;

    la_sample_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (capturing),
        .wr_addr (wptr),
        .wr_data (probe_in),
        .rd_en   (rd_fire),
        .rd_addr (rptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= ST_IDLE;
            wptr      <= '0;
            tptr      <= '0;
            rptr      <= '0;
            cnt       <= '0;
            rd_left   <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            triggered <= 1'b0;
            done      <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            if (capturing) wptr <= wptr + ONE;

            if (abort) begin
                cur_state <= ST_IDLE;
                done      <= 1'b0;
                triggered <= 1'b0;
            end else begin
                case (cur_state)
                    ST_IDLE, ST_DONE: begin
                        if (arm) begin
                            wptr      <= '0;
                            triggered <= 1'b0;
                            done      <= 1'b0;
                            rd_left   <= '0;
                            cnt       <= PRE_LOAD;
                            cur_state <= (PRETRIG == 0) ? ST_WAIT : ST_PRE;
                        end else if (rd_fire) begin
                            rd_valid <= 1'b1;
                            rd_last  <= (rd_left == RD_ONE);
                            rd_left  <= rd_left - RD_ONE;
                            rptr     <= rptr + ONE;
                        end
                    end
                    ST_PRE: begin
                        if (cnt == '0) cur_state <= ST_WAIT;
                        else           cnt <= cnt - ONE;
                    end
                    ST_WAIT: begin
                        if (hit) begin
                            tptr      <= wptr;
                            triggered <= 1'b1;
                            if (POST_N == 1) begin
                                cur_state <= ST_DONE;
                                done      <= 1'b1;
                                rptr      <= wptr - PRE_OFS;
                                rd_left   <= RD_LOAD;
                            end else begin
                                cur_state <= ST_POST;
                                cnt       <= POST_LOAD;
                            end
                        end
                    end
                    ST_POST: begin
                        if (cnt == '0) begin
                            cur_state <= ST_DONE;
                            done      <= 1'b1;
                            rptr      <= tptr - PRE_OFS;
                            rd_left   <= RD_LOAD;
                        end else begin
                            cnt <= cnt - ONE;
                        end
                    end
                    default: cur_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_la_capture_engine.sv
// Directed self-checking bench for la_capture_engine (DEPTH=16, PRETRIG=4).
module tb_la_capture_engine;

    logic       clk = 1'b0;
    logic       rst, arm, abort, rd_en;
    logic [7:0] probe_in, trig_mask, trig_value, rd_data;
    logic       rd_valid, rd_last, triggered, done;
    logic [2:0] state;

    int check_cnt = 0;
    int pass_cnt  = 0;

    la_capture_engine #(.DEPTH(16), .PRETRIG(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .probe_in   (probe_in),
        .arm        (arm),
        .abort      (abort),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_last    (rd_last),
        .state      (state),
        .triggered  (triggered),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        check_cnt++; if (state !== 3'd0) $display("FAIL reset_state got=%0d exp=0", state); else pass_cnt++;
        check_cnt++; if ({done, triggered, rd_valid, rd_last} !== 4'b0000)
            $display("FAIL reset_flags got=%b exp=0000", {done, triggered, rd_valid, rd_last}); else pass_cnt++;
        check_cnt++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data got=%h exp=00", rd_data); else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    // Level trigger on A5 at cycle 30 (also an A5 during PRE that must be ignored).
    task automatic test_level_capture();
        logic [7:0] exp_d;
        trig_mask  = 8'hFF;
        trig_value = 8'hA5;
        for (int i = 0; i <= 41; i++) begin
            arm      = (i == 0);
            probe_in = (i == 30 || i == 2) ? 8'hA5 : 8'(i);
            tick();
            if (i == 0) begin
                check_cnt++; if (state !== 3'd1) $display("FAIL lvl_pre got=%0d exp=1", state); else pass_cnt++;
            end
            if (i == 5) begin
                check_cnt++; if (state !== 3'd2) $display("FAIL lvl_wait got=%0d exp=2", state); else pass_cnt++;
            end
            if (i == 29) begin
                check_cnt++; if (triggered !== 1'b0) $display("FAIL lvl_no_trig got=%b exp=0", triggered); else pass_cnt++;
            end
            if (i == 30) begin
                check_cnt++; if ({state, triggered} !== {3'd3, 1'b1})
                    $display("FAIL lvl_trig got=%0d/%b exp=3/1", state, triggered); else pass_cnt++;
            end
            if (i == 40) begin
                check_cnt++; if (done !== 1'b0) $display("FAIL lvl_early_done got=%b exp=0", done); else pass_cnt++;
            end
            if (i == 41) begin
                check_cnt++; if ({state, done} !== {3'd4, 1'b1})
                    $display("FAIL lvl_done got=%0d/%b exp=4/1", state, done); else pass_cnt++;
            end
        end
        arm   = 1'b0;
        rd_en = 1'b1;
        for (int k = 0; k < 17; k++) begin
            tick();
            exp_d = (k == 4) ? 8'hA5 : 8'(26 + k);
            check_cnt++; if (rd_valid !== (k < 16))
                $display("FAIL rd_valid pop=%0d got=%b exp=%b", k, rd_valid, (k < 16)); else pass_cnt++;
            check_cnt++; if (rd_last !== (k == 15))
                $display("FAIL rd_last pop=%0d got=%b exp=%b", k, rd_last, (k == 15)); else pass_cnt++;
            if (k < 16) begin
                check_cnt++; if (rd_data !== exp_d)
                    $display("FAIL rd_data pop=%0d got=%h exp=%h", k, rd_data, exp_d); else pass_cnt++;
            end
        end
        rd_en = 1'b0;
    endtask

    // mask=00 re-arm from DONE, count cycles to done, then arm mid-readout.
    task automatic test_mask_zero();
        int n;
        trig_mask = 8'h00;
        arm       = 1'b1;
        probe_in  = 8'h00;
        tick();
        arm = 1'b0;
        n   = 0;
        while (done !== 1'b1 && n < 40) begin
            probe_in = 8'(n + 1);
            tick();
            n++;
        end
        check_cnt++; if (n !== 16) $display("FAIL m0_latency got=%0d exp=16", n); else pass_cnt++;
        check_cnt++; if ({state, triggered} !== {3'd4, 1'b1})
            $display("FAIL m0_done got=%0d/%b exp=4/1", state, triggered); else pass_cnt++;
        rd_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_cnt++; if ({rd_valid, rd_data} !== {1'b1, 8'(k + 1)})
                $display("FAIL m0_pop%0d got=%b/%h exp=1/%h", k, rd_valid, rd_data, 8'(k + 1)); else pass_cnt++;
        end
        trig_mask  = 8'hFF;
        trig_value = 8'hA5;
        probe_in   = 8'h00;
        arm        = 1'b1;
        tick();
        arm   = 1'b0;
        rd_en = 1'b0;
        check_cnt++; if ({state, rd_valid, done, triggered} !== {3'd1, 3'b000})
            $display("FAIL rearm_mid_read got=%0d/%b%b%b exp=1/000", state, rd_valid, done, triggered); else pass_cnt++;
    endtask

    task automatic test_abort_arm();
        int n;
        repeat (4) tick();
        check_cnt++; if (state !== 3'd2) $display("FAIL ab_in_wait got=%0d exp=2", state); else pass_cnt++;
        tick();
        abort = 1'b1;
        arm   = 1'b1;
        tick();
        abort = 1'b0;
        arm   = 1'b0;
        check_cnt++; if ({state, done, triggered} !== {3'd0, 2'b00})
            $display("FAIL ab_arm got=%0d/%b%b exp=0/00", state, done, triggered); else pass_cnt++;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check_cnt++; if (rd_valid !== 1'b0) $display("FAIL ab_rd_en got=%b exp=0", rd_valid); else pass_cnt++;
        trig_mask = 8'h00;
        arm       = 1'b1;
        tick();
        arm = 1'b0;
        n   = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check_cnt++; if ({done, triggered} !== 2'b11) $display("FAIL ab_pre_done got=%b exp=11", {done, triggered}); else pass_cnt++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_cnt++; if ({state, done, triggered} !== {3'd0, 2'b00})
            $display("FAIL ab_in_done got=%0d/%b%b exp=0/00", state, done, triggered); else pass_cnt++;
    endtask

    task automatic test_reset_in_post();
        trig_mask = 8'h00;
        arm       = 1'b1;
        tick();
        arm = 1'b0;
        repeat (6) tick();
        check_cnt++; if (state !== 3'd3) $display("FAIL rp_in_post got=%0d exp=3", state); else pass_cnt++;
        rst   = 1'b1;
        arm   = 1'b1;
        abort = 1'b1;
        rd_en = 1'b1;
        tick();
        rst   = 1'b0;
        arm   = 1'b0;
        abort = 1'b0;
        check_cnt++; if ({state, done, triggered, rd_valid, rd_last, rd_data} !== 15'd0)
            $display("FAIL rp_outputs got=%0d/%b%b%b%b/%h exp=0/0000/00",
                     state, done, triggered, rd_valid, rd_last, rd_data); else pass_cnt++;
        tick();
        rd_en = 1'b0;
        check_cnt++; if ({state, rd_valid} !== 4'd0)
            $display("FAIL rp_rd_ignored got=%0d/%b exp=0/0", state, rd_valid); else pass_cnt++;
    endtask

`ifdef LA_EDGE_TRIG_EN
    task automatic test_edge_trig();
        trig_mask  = 8'h01;
        trig_value = 8'h01;
        probe_in   = 8'h01;
        arm        = 1'b1;
        tick();
        arm = 1'b0;
        repeat (12) tick();
        check_cnt++; if ({state, triggered} !== {3'd2, 1'b0})
            $display("FAIL edge_hold got=%0d/%b exp=2/0", state, triggered); else pass_cnt++;
        probe_in = 8'h00;
        tick();
        check_cnt++; if (state !== 3'd2) $display("FAIL edge_fall got=%0d exp=2", state); else pass_cnt++;
        probe_in = 8'h01;
        tick();
        check_cnt++; if ({state, triggered} !== {3'd3, 1'b1})
            $display("FAIL edge_rise got=%0d/%b exp=3/1", state, triggered); else pass_cnt++;
    endtask
`endif

    initial begin
        rst        = 1'b1;
        arm        = 1'b0;
        abort      = 1'b0;
        rd_en      = 1'b0;
        probe_in   = 8'h00;
        trig_mask  = 8'h00;
        trig_value = 8'h00;
        test_reset();
`ifdef LA_EDGE_TRIG_EN
        test_edge_trig();
`else
        test_level_capture();
        test_mask_zero();
        test_abort_arm();
        test_reset_in_post();
`endif
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
